// File: rtl/mul_div_pkg.sv
// Shared op encodings and FSM state codes for the iterative multiply/divide engine.
package mul_div_pkg;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_MUL  = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration: BITS_PER_CYCLE shift-add (MUL) or restoring-subtract (DIV) bits.
module mul_div_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     opnd,
  input  logic [2*WIDTH-1:0]   acc_in,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;

  // MUL: acc = {partial, multiplier}, consumed LSB first.
  // DIV: acc = {remainder, dividend/quotient}, quotient bits shifted in from the right.
  always_comb begin
    acc = acc_in;
    sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        sum = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        if (sum >= {1'b0, opnd}) begin
          sum = sum - {1'b0, opnd};
          acc = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
          acc = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        acc = {sum, acc[WIDTH-1:1]};
      end
    end
    acc_out = acc;
  end

endmodule

// File: rtl/mul_div_engine.sv
// Iterative signed/unsigned multiplier and restoring divider with valid/ready handshakes.
module mul_div_engine
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_src0,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [1:0]       in_op,
  input  logic             in_sign,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res0,
  output logic [WIDTH-1:0] out_res1,
  output logic [1:0]       out_op
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = ($clog2(N) > 0) ? $clog2(N) : 1;

  logic [1:0]         state_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   opnd_q;
  logic [1:0]         op_q;
  logic               neg_lo_q, neg_hi_q;
  logic [CW-1:0]      cnt_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  always_comb begin
    a_neg = in_sign & in_src0[WIDTH-1];
    b_neg = in_sign & in_src1[WIDTH-1];
    a_mag = a_neg ? (~in_src0 + 1'b1) : in_src0;
    b_mag = b_neg ? (~in_src1 + 1'b1) : in_src1;
  end

  mul_div_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .is_div  (op_q == OP_DIV),
    .opnd    (opnd_q),
    .acc_in  (acc_q),
    .acc_out (acc_step)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= OP_NONE;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      cnt_q    <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && (in_op == OP_MUL || in_op == OP_DIV)) begin
            op_q     <= in_op;
            cnt_q    <= '0;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= (in_op == OP_DIV) ? a_neg : (a_neg ^ b_neg);
            if (in_op == OP_MUL) begin
              acc_q   <= {{WIDTH{1'b0}}, b_mag};
              opnd_q  <= a_mag;
              state_q <= ST_CALC;
            end else if (in_src1 == '0) begin
              // Divide by zero bypasses the datapath entirely.
              acc_q   <= {in_src0, {WIDTH{1'b1}}};
              state_q <= ST_DONE;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, a_mag};
              opnd_q  <= b_mag;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (op_q == OP_MUL) begin
            acc_q <= neg_lo_q ? (~acc_q + 1'b1) : acc_q;
          end else begin
            acc_q <= {neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH],
                      neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]};
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_res0  = acc_q[WIDTH-1:0];
  assign out_res1  = acc_q[2*WIDTH-1:WIDTH];
  assign out_op    = op_q;

endmodule

// File: tb/tb_mul_div_engine.sv
// Directed checks on a default-size engine plus randomized checks on a 16-bit, 4-bit/cycle engine.
module tb_mul_div_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  logic [31:0] w_src0 = '0, w_src1 = '0, w_res0, w_res1;
  logic [1:0]  w_op = '0, w_out_op;
  logic        w_sign = 1'b0, w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0;

  logic [15:0] s_src0 = '0, s_src1 = '0, s_res0, s_res1;
  logic [1:0]  s_op = '0, s_out_op;
  logic        s_sign = 1'b0, s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mul_div_engine u_wide (
    .clock     (clk),
    .reset     (reset),
    .flush     (flush),
    .in_src0   (w_src0),
    .in_src1   (w_src1),
    .in_op     (w_op),
    .in_sign   (w_sign),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_res0  (w_res0),
    .out_res1  (w_res1),
    .out_op    (w_out_op)
  );

  mul_div_engine #(
    .WIDTH          (16),
    .BITS_PER_CYCLE (4)
  ) u_small (
    .clock     (clk),
    .reset     (reset),
    .flush     (flush),
    .in_src0   (s_src0),
    .in_src1   (s_src1),
    .in_op     (s_op),
    .in_sign   (s_sign),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_res0  (s_res0),
    .out_res1  (s_res1),
    .out_op    (s_out_op)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Presents one op, returns cycles from the accept edge to the first visible out_valid.
  task automatic go_w(input logic [1:0] op, input logic sign, input logic [31:0] a, b,
                      output int lat);
    @(negedge clk);
    w_op = op; w_sign = sign; w_src0 = a; w_src1 = b; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic go_s(input logic [1:0] op, input logic sign, input logic [15:0] a, b,
                      output int lat);
    @(negedge clk);
    s_op = op; s_sign = sign; s_src0 = a; s_src1 = b; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack_w();
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
  endtask

  task automatic ack_s();
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  // Reference: plain integer arithmetic, C-style truncating division.
  function automatic void ref16(input logic [1:0] op, input logic sign, input logic [15:0] a, b,
                                output logic [15:0] r0, output logic [15:0] r1);
    longint sa, sb, p, q, r;
    sa = sign ? longint'($signed(a)) : longint'(a);
    sb = sign ? longint'($signed(b)) : longint'(b);
    if (op == 2'd1) begin
      p  = sa * sb;
      r0 = p[15:0];
      r1 = p[31:16];
    end else if (b == 16'd0) begin
      r0 = 16'hFFFF;
      r1 = a;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      r0 = q[15:0];
      r1 = r[15:0];
    end
  endfunction

  initial begin
    int lat;
    int bad;
    int seen;
    logic [1:0]  rop;
    logic        rsign;
    logic [15:0] ra, rb, e0, e1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("reset_in_ready", 64'(w_in_ready), 64'd1);
    check("reset_out_valid", 64'(w_out_valid), 64'd0);
    check("reset_res0", 64'(w_res0), 64'd0);
    check("reset_res1", 64'(w_res1), 64'd0);
    check("reset_out_op", 64'(w_out_op), 64'd0);

    go_w(2'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    check("mulu_lat", 64'(lat), 64'd34);
    check("mulu_res1", 64'(w_res1), 64'hFFFFFFFE);
    check("mulu_res0", 64'(w_res0), 64'h00000001);
    check("mulu_op", 64'(w_out_op), 64'd1);
    ack_w();
    check("after_ack_in_ready", 64'(w_in_ready), 64'd1);

    go_w(2'd2, 1'b1, 32'hFFFFFFF9, 32'd2, lat);
    check("divs_lat", 64'(lat), 64'd34);
    check("divs_q", 64'(w_res0), 64'hFFFFFFFD);
    check("divs_r", 64'(w_res1), 64'hFFFFFFFF);
    ack_w();

    go_w(2'd2, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
    check("divovf_lat", 64'(lat), 64'd34);
    check("divovf_q", 64'(w_res0), 64'h80000000);
    check("divovf_r", 64'(w_res1), 64'd0);
    ack_w();

    go_w(2'd2, 1'b0, 32'd100, 32'd0, lat);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_q", 64'(w_res0), 64'hFFFFFFFF);
    check("div0_r", 64'(w_res1), 64'd100);
    check("div0_op", 64'(w_out_op), 64'd2);
    ack_w();

    // Held result under backpressure.
    go_w(2'd1, 1'b1, 32'hFFFFFFFD, 32'd5, lat);
    check("mul_hold_res1", 64'(w_res1), 64'hFFFFFFFF);
    check("mul_hold_res0", 64'(w_res0), 64'hFFFFFFF1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (w_res1 !== 32'hFFFFFFFF || w_res0 !== 32'hFFFFFFF1 || w_out_op !== 2'd1 ||
          w_out_valid !== 1'b1 || w_in_ready !== 1'b0) bad++;
    end
    check("hold_stable_cycles_bad", 64'(bad), 64'd0);
    ack_w();
    check("hold_release_in_ready", 64'(w_in_ready), 64'd1);

    // Reserved op is silently dropped.
    go_w(2'd3, 1'b0, 32'd1, 32'd1, lat);
    check("rsvd_no_valid", 64'(w_out_valid), 64'd0);
    check("rsvd_in_ready", 64'(w_in_ready), 64'd1);

    // Flush five cycles into a DIV.
    @(negedge clk);
    w_op = 2'd2; w_sign = 1'b0; w_src0 = 32'd1000; w_src1 = 32'd7; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", 64'(w_out_valid), 64'd0);
    check("flush_in_ready", 64'(w_in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (w_out_valid) seen++;
    end
    check("flush_no_late_valid", 64'(seen), 64'd0);

    // Reset in the middle of a MUL.
    @(negedge clk);
    w_op = 2'd1; w_sign = 1'b0; w_src0 = 32'd123; w_src1 = 32'd456; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("rst_mid_out_valid", 64'(w_out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(w_in_ready), 64'd1);
    check("rst_mid_res0", 64'(w_res0), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (w_out_valid) seen++;
    end
    check("rst_no_late_valid", 64'(seen), 64'd0);

    go_w(2'd1, 1'b0, 32'd6, 32'd7, lat);
    check("mul67_lat", 64'(lat), 64'd34);
    check("mul67_res0", 64'(w_res0), 64'd42);
    check("mul67_res1", 64'(w_res1), 64'd0);
    ack_w();

    // Randomized run on the narrow, fast engine.
    for (int n = 0; n < 200; n++) begin
      rop   = 2'($urandom_range(1, 2));
      rsign = 1'($urandom_range(0, 1));
      ra    = 16'($urandom);
      case ($urandom_range(0, 15))
        0:       rb = 16'd0;
        1:       rb = 16'hFFFF;
        2:       begin ra = 16'h8000; rb = 16'hFFFF; end
        default: rb = 16'($urandom);
      endcase
      ref16(rop, rsign, ra, rb, e0, e1);
      go_s(rop, rsign, ra, rb, lat);
      check($sformatf("rnd%0d_lat", n), 64'(lat),
            (rop == 2'd2 && rb == 16'd0) ? 64'd1 : 64'd6);
      check($sformatf("rnd%0d_res0 op=%0d s=%0d a=%0h b=%0h", n, rop, rsign, ra, rb),
            64'(s_res0), 64'(e0));
      check($sformatf("rnd%0d_res1 op=%0d s=%0d a=%0h b=%0h", n, rop, rsign, ra, rb),
            64'(s_res1), 64'(e1));
      check($sformatf("rnd%0d_op", n), 64'(s_out_op), 64'(rop));
      ack_s();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_engine.md
MUL_DIV_ENGINE -- requirements
Module: mul_div_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; legal values 8..64.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: quotient/multiplier bits retired per iteration; legal values 1, 2, 4; WIDTH % BITS_PER_CYCLE == 0.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port flush  in  1  abort any in-flight operation.
REQ-006 SHALL have ports in_src0 / in_src1  in  WIDTH each  operand A (multiplicand/dividend) and operand B (multiplier/divisor).
REQ-007 SHALL have port in_op  in  2  operation: 1 = MUL, 2 = DIV, 0 and 3 = reserved.
REQ-008 SHALL have port in_sign  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have ports in_valid  in  1 and in_ready  out  1  input handshake.
REQ-010 SHALL have ports out_valid  out  1 and out_ready  in  1  output handshake.
REQ-011 SHALL have ports out_res0 / out_res1  out  WIDTH each  MUL: product low/high; DIV: quotient/remainder.
REQ-012 SHALL have port out_op  out  2  op code of the result currently presented.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept when in_valid & in_ready at a rising edge.
REQ-015 SHALL, on accept of MUL/DIV, latch the operand magnitudes, result signs, op and in_sign, then go to CALC.
REQ-016 SHALL drop accepted ops 0/3 and stay in IDLE; no out_valid is generated.
REQ-017 SHALL remain in CALC for exactly N = WIDTH/BITS_PER_CYCLE cycles: MUL uses shift-add, DIV uses restoring division.
REQ-018 SHALL spend one cycle in FIX for sign correction, then enter DONE.
REQ-019 SHALL assert out_valid only in DONE; out_valid first rises N+2 cycles after the accept edge (34 for defaults).
REQ-020 SHALL hold out_res0, out_res1 and out_op stable while out_valid & !out_ready.
REQ-021 SHALL go DONE -> IDLE on out_valid & out_ready; no new accept occurs in that same cycle (in_ready = 0 in DONE).
REQ-022 SHALL, for signed MUL, return the 2*WIDTH two's-complement product; for unsigned MUL, the 2*WIDTH unsigned product.
REQ-023 SHALL, for signed DIV, truncate the quotient toward zero; the remainder takes the sign of the dividend.
REQ-024 SHALL, for DIV by zero, skip CALC and FIX (accept -> DONE in 1 cycle) and return quotient = all ones, remainder = in_src0.
REQ-025 SHALL, for signed DIV of most-negative by -1, return quotient = most-negative and remainder = 0, with normal latency.
REQ-026 SHALL, when flush = 1, force IDLE at the next edge from any state and discard the result; out_valid = 0 in that next cycle. flush has priority over accept and out handshake.
REQ-027 SHALL drive out_res0, out_res1 and out_op from registers; no combinational path from in_* to out_*.

Reset
REQ-028 SHALL, when reset = 0 at a rising edge, enter IDLE: in_ready = 1 after release, out_valid = 0, out_res0 = 0, out_res1 = 0, out_op = 0.
REQ-029 SHALL, on reset mid-operation, abandon the operation silently; reset has priority over flush.

Structure
REQ-030 SHALL place op encodings (OP_NONE=0, OP_MUL=1, OP_DIV=2, OP_RSVD=3) and the FSM state enum in shared package mul_div_pkg.
REQ-031 SHALL factor one iteration step (BITS_PER_CYCLE shift-add or restoring-subtract bits, combinational) into sub-module mul_div_step, instantiated once.
REQ-032 SHALL share a single 2*WIDTH accumulator/shift register between MUL and DIV.

Verification
REQ-033 Defaults; MUL unsigned 0xFFFFFFFF x 0xFFFFFFFF -> res1 = 0xFFFFFFFE, res0 = 0x00000001; out_valid 34 cycles after accept.
REQ-034 Defaults; DIV signed -7 / 2 -> res0 = 0xFFFFFFFD (-3), res1 = 0xFFFFFFFF (-1); DIV signed 0x80000000 / 0xFFFFFFFF -> res0 = 0x80000000, res1 = 0.
REQ-035 DIV unsigned 100 / 0 -> out_valid 1 cycle after accept, res0 = 0xFFFFFFFF, res1 = 100.
REQ-036 MUL signed -3 x 5 with out_ready held 0 for 10 cycles -> res1:res0 = 0xFFFFFFFF:0xFFFFFFF1, stable throughout; in_ready = 0 until the handshake.
REQ-037 flush pulse 5 cycles into a DIV, then reset = 0 pulse mid-MUL -> each time: no out_valid, IDLE and in_ready = 1 the next cycle; the following MUL 6 x 7 returns 42.
REQ-038 BITS_PER_CYCLE = 4, WIDTH = 16: 200 random signed/unsigned MUL/DIV vs reference model; out_valid at accept + 6 (non-zero divisor).
